bs_rr_schdlr_8drvrs: RTL
========================

Name: bs_rr_schdlr_8drvrs

Overview:
Round-robin scheduler that shares a single parallel bus among up to 8 driver FIFOs, each first-word-fall-through. It picks one pending driver, pops its head word and decodes the destination field. It then waits for the destination FIFO(s) to have room and pushes the word to one driver, or broadcasts it to many. It sits between the driver FIFO bank and the bus fabric, one instance per bus.

Parameters:
bits, 32, data word width; destination ID is D[bits-1 -: 8]
drvrs, 8, number of drivers (2..8)
broadcast, {8{1'b1}}, bit i=1 lets driver i receive broadcast words
BCAST_ID, 8'hFF, destination ID meaning broadcast
TMO, 16, stall cycles before a word is dropped (used only with BS_TMO_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
pndng  in  drvrs  bit i=1: driver i FIFO non-empty
D_pop  in  drvrs*bits  head words, driver i at [i*bits +: bits]
full  in  drvrs  bit i=1: driver i receive FIFO full
pop  out  drvrs  one-hot pop strobe
push  out  drvrs  push strobe mask
D_push  out  bits  word on bus, common to all receivers
gnt  out  drvrs  one-hot current grant, 0 when idle
busy  out  1  1 when state != IDLE
err_dst  out  1  1-cycle pulse: invalid destination, word discarded
drop  out  1  1-cycle pulse: word dropped on timeout (BS_TMO_EN only)

Behaviour:
- Reset (synchronous, takes priority mid-transfer): state=IDLE, last=drvrs-1, gnt=0, pop=0, push=0, D_push=0, err_dst=0, drop=0, busy=0. An in-flight word is lost; the FIFO was already popped.
- IDLE: if pndng!=0, winner = first set bit searching from last+1 upward, with wrap-around. Register gnt=onehot(winner), last=winner, go POP. If pndng==0, stay.
- POP, exactly 1 cycle:
  - pop=gnt.
  - Capture D_pop[winner] into the data register, which drives D_push.
  - Compute dmask:
    - ID<drvrs: onehot(ID). Self-addressing is allowed.
    - ID==BCAST_ID: broadcast & ~gnt, limited to drvrs bits.
    - Anything else: invalid.
  - Invalid ID: pulse err_dst next cycle, go IDLE, nothing pushed.
  - dmask==0 (broadcast with no eligible receiver): go IDLE silently.
  - Otherwise go DLVR.
- DLVR: when (dmask & full)==0, push=dmask for exactly 1 cycle (Mealy on full), then go IDLE, gnt cleared. Otherwise hold. A broadcast is all-or-nothing: no partial pushes.
- D_push is stable from the cycle after POP until the next POP.
- Best-case latency: pndng rises at cycle 0 → pop at cycle 1 → push at cycle 2. Next arbitration is at cycle 3.
- Throughput: at most 1 word per 3 cycles.
- Fairness: a driver that keeps pndng high is served within drvrs transfers.
- pndng bits for i>=drvrs are ignored.
- pndng changes during POP/DLVR have no effect until IDLE.
- pop and push are never asserted in the same cycle.

Optional Feature:
BS_TMO_EN
- Defined: a stall counter starts at 0 on entry to DLVR and increments on each blocked cycle. When it reaches TMO, drop pulses for 1 cycle, no push occurs, and state goes to IDLE.
- Undefined: DLVR waits indefinitely, drop is tied 0, and the counter is not instantiated.

Test Plan:
- Reset, then pndng=8'h00 for 10 cycles → pop=push=0, busy=0, gnt=0 throughout.
- pndng=8'h04, D_pop[2]=32'h05AB_CDEF, full=0 → pop=8'h04 at cycle 1, push=8'h20 and D_push=32'h05AB_CDEF at cycle 2, busy drops at cycle 3.
- pndng=8'hFF held, all IDs 0, full=0 → grants in order 0,1,...,7,0, one every 3 cycles, push=8'h01 each time.
- Driver 3 sends ID 8'hFF with broadcast=8'hFF, full=8'h10 for 4 cycles → push stays 0 while blocked, then push=8'hF7 once in a single cycle.
- Driver 1 sends ID 8'h0A → err_dst pulses once, push stays 0, driver 2 pending is granted next.
- With BS_TMO_EN, TMO=16: destination 5 held full → drop pulses after 16 blocked cycles, no push. Separately, reset asserted in DLVR → next cycle state IDLE and all outputs 0.

Source files
------------

// File: rtl/bs_rr_schdlr_8drvrs.sv
// Round-robin bus scheduler: pops one word at a time from up to 8 driver FIFOs and delivers it to one or all receivers.
// Optional macro BS_TMO_EN: drop a word whose destination stays full for TMO cycles.
module bs_rr_schdlr_8drvrs #(
  parameter int unsigned bits      = 32,
  parameter int unsigned drvrs     = 8,
  parameter logic [7:0]  broadcast = {8{1'b1}},
  parameter logic [7:0]  BCAST_ID  = 8'hFF,
  parameter int unsigned TMO       = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [drvrs-1:0]      pndng,
  input  logic [drvrs*bits-1:0] D_pop,
  input  logic [drvrs-1:0]      full,
  output logic [drvrs-1:0]      pop,
  output logic [drvrs-1:0]      push,
  output logic [bits-1:0]       D_push,
  output logic [drvrs-1:0]      gnt,
  output logic                  busy,
  output logic                  err_dst,
  output logic                  drop
);

  localparam int LW = (drvrs > 1) ? $clog2(drvrs) : 1;
  localparam logic [drvrs-1:0] ONE = {{(drvrs-1){1'b0}}, 1'b1};

  if (drvrs < 2 || drvrs > 8 || bits < 8 || TMO < 1) begin : g_param_chk
    $error("bs_rr_schdlr_8drvrs: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, POP, DLVR} state_t;

  state_t            state_q;
  logic [LW-1:0]     last_q;
  logic [drvrs-1:0]  gnt_q;
  logic [drvrs-1:0]  pop_q;
  logic [drvrs-1:0]  dmask_q;
  logic [bits-1:0]   data_q;
  logic              err_q;

  logic [LW-1:0]     win_d;
  logic [bits-1:0]   head_d;
  logic [7:0]        id_d;
  logic [drvrs-1:0]  dmask_d;
  logic              id_ok_d;
  logic              blocked_d;
  int                idx;
  logic              found;

  // Search starts just above the previous winner so every pending driver gets a turn.
  always_comb begin
    found = 1'b0;
    idx   = 0;
    win_d = last_q;
    for (int k = 1; k <= int'(drvrs); k++) begin
      idx = (int'(last_q) + k) % int'(drvrs);
      if (!found && pndng[LW'(idx)]) begin
        found = 1'b1;
        win_d = LW'(idx);
      end
    end
  end

  assign head_d = D_pop[int'(last_q)*bits +: bits];
  assign id_d   = head_d[bits-1 -: 8];

  always_comb begin
    id_ok_d = 1'b1;
    dmask_d = '0;
    if (int'(id_d) < int'(drvrs)) begin
      dmask_d = ONE << id_d;
    end else if (id_d == BCAST_ID) begin
      dmask_d = broadcast[drvrs-1:0] & ~gnt_q;
    end else begin
      id_ok_d = 1'b0;
    end
  end

  assign blocked_d = |(dmask_q & full);

`ifdef BS_TMO_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt_q;
  logic          drop_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LW'(drvrs - 1);
      gnt_q   <= '0;
      pop_q   <= '0;
      dmask_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifdef BS_TMO_EN
      cnt_q   <= '0;
      drop_q  <= 1'b0;
`endif
    end else begin
      err_q <= 1'b0;
      pop_q <= '0;
`ifdef BS_TMO_EN
      drop_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (|pndng) begin
            gnt_q   <= ONE << win_d;
            pop_q   <= ONE << win_d;
            last_q  <= win_d;
            state_q <= POP;
          end
        end
        POP: begin
          data_q  <= head_d;
          dmask_q <= dmask_d;
          if (!id_ok_d) begin
            err_q   <= 1'b1;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else if (dmask_d == '0) begin
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            state_q <= DLVR;
`ifdef BS_TMO_EN
            cnt_q   <= '0;
`endif
          end
        end
        DLVR: begin
          if (!blocked_d) begin
            gnt_q   <= '0;
            state_q <= IDLE;
`ifdef BS_TMO_EN
          end else if (cnt_q == CW'(TMO - 1)) begin
            drop_q  <= 1'b1;
            gnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        default: begin
          gnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Push fires combinationally in the first DLVR cycle where every target has room.
  assign push    = (state_q == DLVR && !blocked_d && !reset) ? dmask_q : '0;
  assign pop     = pop_q;
  assign gnt     = gnt_q;
  assign D_push  = data_q;
  assign busy    = (state_q != IDLE);
  assign err_dst = err_q;
`ifdef BS_TMO_EN
  assign drop    = drop_q;
`else
  assign drop    = 1'b0;
`endif

endmodule
